// File: rtl/timer_display_scan.sv
// ---------------------------------------------------------------------------
// timer_display_scan
//
// Multiplexed common-anode seven-segment scanner for the BCD outputs of a
// timer10 counter chain. One digit is lit at a time for SCAN_DIV cycles.
// A shadow register captures new digits on `load`. The visible display
// register copies the shadow only at frame boundaries, so a frame is never
// torn. Non-BCD codes are shown as a dash. A `rollover` pulse starts a
// flash sequence in which every odd-numbered frame of the countdown is dark.
//
// Optional feature (compile-time macro):
//   TIMER_DISP_LZ_BLANK_EN - blank leading zeros (digit 0 is always shown,
//                            and non-BCD codes count as nonzero).
// ---------------------------------------------------------------------------
module timer_display_scan #(
   parameter int DIGITS       = 4,     // 1..8, digit 0 is least significant
   parameter int SCAN_DIV     = 1000,  // cycles per digit slot, >= 2
   parameter int FLASH_FRAMES = 8      // 1..255 frames of flashing
) (
   input  logic                  Clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   digits_in,
   input  logic                  load,
   input  logic                  rollover,
   input  logic                  enable,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_tick,
   output logic                  flashing
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
   localparam logic [7:0]       FLASH_LOAD = 8'(FLASH_FRAMES);

   // Segment pattern for one BCD code, active low {g,f,e,d,c,b,a}.
   function automatic logic [6:0] decode_bcd(input logic [3:0] code);
      logic [6:0] pattern;
      case (code)
         4'd0:    pattern = 7'b1000000;
         4'd1:    pattern = 7'b1111001;
         4'd2:    pattern = 7'b0100100;
         4'd3:    pattern = 7'b0110000;
         4'd4:    pattern = 7'b0011001;
         4'd5:    pattern = 7'b0010010;
         4'd6:    pattern = 7'b0000010;
         4'd7:    pattern = 7'b1111000;
         4'd8:    pattern = 7'b0000000;
         4'd9:    pattern = 7'b0010000;
         default: pattern = 7'b0111111;   // dash for 10..15
      endcase
      return pattern;
   endfunction

   // Architectural state
   logic [4*DIGITS-1:0] shadow_q, shadow_d;
   logic [4*DIGITS-1:0] disp_q,   disp_d;
   logic [DIV_W-1:0]    div_q,    div_d;
   logic [IDX_W-1:0]    idx_q,    idx_d;
   logic [7:0]          flash_q,  flash_d;

   // Registered outputs
   logic [6:0]          seg_q,    seg_d;
   logic [DIGITS-1:0]   an_q,     an_d;
   logic                frame_tick_q, frame_tick_d;

   // Decode helpers
   logic                frame_end;
   logic [3:0]          cur_digit;
   logic                cur_blank;
   logic [DIGITS-1:0]   lz_blank;

   // Per-digit leading-zero blank mask, derived from the visible display
   // register so blanking changes only at frame boundaries.
`ifdef TIMER_DISP_LZ_BLANK_EN
   logic zero_run;

   always_comb begin
      // NOTE: every variable assigned in a combinational block gets a default
      // first; a path that leaves one unassigned would infer a latch.
      lz_blank = '0;
      zero_run = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run    = zero_run && (disp_q[4*i +: 4] == 4'd0);
         lz_blank[i] = zero_run;
      end
   end
`else
   assign lz_blank = '0;
`endif

   // Select the digit addressed by the scan index and its blank flag.
   always_comb begin
      cur_digit = '0;
      cur_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_digit = disp_q[4*i +: 4];
            cur_blank = lz_blank[i];
         end
      end
   end

   // Scan divider, digit index, buffering and flash counter next state.
   always_comb begin
      shadow_d = shadow_q;
      disp_d   = disp_q;
      div_d    = div_q;
      idx_d    = idx_q;
      flash_d  = flash_q;

      frame_end = enable && (div_q == DIV_LAST) && (idx_q == IDX_LAST);

      // The shadow keeps accepting new digits even while scanning is frozen.
      if (load) begin
         shadow_d = digits_in;
      end

      if (enable) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         end else begin
            div_d = div_q + 1'b1;
         end
      end

      // The display takes the shadow as it stood before this edge, so a load
      // landing on the boundary is seen one frame later.
      if (frame_end) begin
         disp_d = shadow_q;
         if (flash_q != 8'd0) begin
            flash_d = flash_q - 8'd1;
         end
      end

      // A new rollover restarts the sequence and beats a boundary decrement.
      if (rollover) begin
         flash_d = FLASH_LOAD;
      end
   end

   // Output stage: segment and anode patterns for the current slot.
   always_comb begin
      seg_d        = 7'h7F;
      an_d         = '1;
      frame_tick_d = frame_end;

      if (enable) begin
         seg_d = decode_bcd(cur_digit);
         // Odd flash count darkens the whole frame.
         if (!flash_q[0] && !cur_blank) begin
            for (int i = 0; i < DIGITS; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  an_d[i] = 1'b0;
               end
            end
         end
      end
   end

   // State and output registers with asynchronous active-high reset.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         shadow_q     <= '0;
         disp_q       <= '0;
         div_q        <= '0;
         idx_q        <= '0;
         flash_q      <= '0;
         seg_q        <= 7'h7F;
         an_q         <= '1;
         frame_tick_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         shadow_q     <= shadow_d;
         disp_q       <= disp_d;
         div_q        <= div_d;
         idx_q        <= idx_d;
         flash_q      <= flash_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_tick = frame_tick_q;
   assign flashing   = (flash_q != 8'd0);

endmodule

// File: tb/tb_timer_display_scan.sv
// ---------------------------------------------------------------------------
// tb_timer_display_scan
//
// Scoreboard bench for timer_display_scan with DIGITS=4, SCAN_DIV=4,
// FLASH_FRAMES=4. The stimulus process pushes the expected output for each
// cycle (tagged with the cycle number since reset release). A monitor on the
// falling edge pops and compares. Expectations follow the leading-zero
// blanking setting when TIMER_DISP_LZ_BLANK_EN is defined.
// ---------------------------------------------------------------------------
module tb_timer_display_scan;

   localparam int DIGITS       = 4;
   localparam int SCAN_DIV     = 4;
   localparam int FLASH_FRAMES = 4;

`ifdef TIMER_DISP_LZ_BLANK_EN
   localparam bit LZ_EN = 1'b1;
`else
   localparam bit LZ_EN = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        reset;
   logic [15:0] digits_in;
   logic        load;
   logic        rollover;
   logic        enable;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_tick;
   logic        flashing;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;   // posedges since the last reset release

   typedef struct {
      int         tag;
      logic [3:0] an;
      logic [6:0] seg;
      bit         seg_care;
      logic       ft;
      logic       fl;
   } exp_t;

   exp_t exp_q[$];

   timer_display_scan #(
      .DIGITS       (DIGITS),
      .SCAN_DIV     (SCAN_DIV),
      .FLASH_FRAMES (FLASH_FRAMES)
   ) dut (
      .Clk        (Clk),
      .reset      (reset),
      .digits_in  (digits_in),
      .load       (load),
      .rollover   (rollover),
      .enable     (enable),
      .seg        (seg),
      .an         (an),
      .frame_tick (frame_tick),
      .flashing   (flashing)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Segment table for the displayed code.
   function automatic logic [6:0] seg_of(input logic [3:0] code);
      logic [6:0] table_v [16];
      table_v = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                  7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
      return table_v[code];
   endfunction

   // Whether digit j of val is lit under the current blanking setting.
   function automatic bit digit_shown(input logic [15:0] val, input int j);
      bit nz;
      nz = (j == 0) || ((val >> (4 * j)) != 16'd0);
      return LZ_EN ? nz : 1'b1;
   endfunction

   task automatic push_one(input int tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                           input bit care, input logic ft_e, input logic fl_e);
      exp_t e;
      e.tag      = tag;
      e.an       = an_e;
      e.seg      = seg_e;
      e.seg_care = care;
      e.ft       = ft_e;
      e.fl       = fl_e;
      exp_q.push_back(e);
   endtask

   // Expected outputs for one frame starting at cycle `start`. An optional
   // pause of pause_len dark cycles is inserted before lit position pause_at.
   task automatic push_frame(input int start, input logic [15:0] val, input bit dark,
                             input int fl_lo, input int fl_hi,
                             input int pause_at, input int pause_len, input int cap);
      int         t;
      int         j;
      bit         lit;
      logic [3:0] an_e;
      t = start;
      for (int k = 0; k < 16; k++) begin
         if (k == pause_at) begin
            for (int p = 0; p < pause_len; p++) begin
               if (t <= cap) push_one(t, 4'hF, 7'h7F, 1'b1, 1'b0, (t >= fl_lo && t <= fl_hi));
               t++;
            end
         end
         j    = k / 4;
         lit  = !dark && digit_shown(val, j);
         an_e = lit ? ~(4'b0001 << j) : 4'hF;
         if (t <= cap) push_one(t, an_e, seg_of(val[4*j +: 4]), lit, (k == 15), (t >= fl_lo && t <= fl_hi));
         t++;
      end
   endtask

   // Monitor: compare whatever expectation is due on this cycle.
   always @(negedge Clk) begin
      exp_t e;
      if (!reset) begin
         while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
            e = exp_q.pop_front();
            check("missed expectation tag", cyc, e.tag);
         end
         if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
            e = exp_q.pop_front();
            check($sformatf("an @%0d", cyc), an, e.an);
            if (e.seg_care) check($sformatf("seg @%0d", cyc), seg, e.seg);
            check($sformatf("frame_tick @%0d", cyc), frame_tick, e.ft);
            check($sformatf("flashing @%0d", cyc), flashing, e.fl);
         end
      end
   end

   task automatic goto(input int target);
      while (cyc < target) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic pulse_load(input int edge_n, input logic [15:0] val);
      goto(edge_n - 1);
      digits_in = val;
      load      = 1'b1;
      goto(edge_n);
      load      = 1'b0;
   endtask

   task automatic pulse_roll(input int edge_n);
      goto(edge_n - 1);
      rollover = 1'b1;
      goto(edge_n);
      rollover = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " seg"},        seg,        7'h7F);
      check({tag, " an"},         an,         4'hF);
      check({tag, " frame_tick"}, frame_tick, 1'b0);
      check({tag, " flashing"},   flashing,   1'b0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish at time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      load      = 1'b0;
      rollover  = 1'b0;
      enable    = 1'b1;
      digits_in = 16'h0000;
      #2;
      check_reset_outputs("reset before clock");
      repeat (2) @(posedge Clk);
      #1;
      check_reset_outputs("reset held");

      // Expected timeline for the main session (frame f covers 16f+1..16f+16).
      push_frame(  1, 16'h0000, 1'b0,   1,    0, -1,  0, 9999);
      push_frame( 17, 16'h1234, 1'b0,   1,    0, -1,  0, 9999);
      push_frame( 33, 16'h1234, 1'b0,   1,    0, -1,  0, 9999);  // load on boundary
      push_frame( 49, 16'h5678, 1'b0,   1,    0, -1,  0, 9999);
      push_frame( 65, 16'h00A9, 1'b0,  70, 9999, -1,  0, 9999);  // rollover at 70
      push_frame( 81, 16'h00A9, 1'b1,   0, 9999, -1,  0, 9999);  // count 3 dark
      push_frame( 97, 16'h00A9, 1'b0,   0, 9999, -1,  0, 9999);  // count 2 lit
      push_frame(113, 16'h00A9, 1'b1,   0,  127, -1,  0, 9999);  // count 1 dark
      push_frame(129, 16'h00A9, 1'b0,   1,    0, -1,  0, 9999);
      push_frame(145, 16'h00A9, 1'b0,   1,    0, 10, 10, 9999);  // disable pause
      push_frame(171, 16'h00A9, 1'b0,   1,    0, -1,  0, 9999);
      push_frame(187, 16'h0050, 1'b0,   1,    0, -1,  0, 9999);
      push_frame(203, 16'h0050, 1'b0, 205, 9999, -1,  0,  216);

      @(negedge Clk);
      #1;
      reset = 1'b0;

      pulse_load(2,  16'h1234);
      pulse_load(32, 16'h5678);
      pulse_load(50, 16'h00A9);
      pulse_roll(70);
      goto(154);
      enable = 1'b0;
      goto(164);
      enable = 1'b1;
      pulse_load(175, 16'h0050);
      pulse_roll(205);

      // Asynchronous reset while flashing at index 3.
      goto(216);
      @(negedge Clk);
      #1;
      reset = 1'b1;
      #1;
      check_reset_outputs("async reset mid-frame");
      check("queue drained before reset", exp_q.size(), 0);

      repeat (2) @(posedge Clk);
      push_frame(1, 16'h0000, 1'b0, 1, 0, -1, 0, 16);
      @(negedge Clk);
      #1;
      reset = 1'b0;
      goto(18);
      check("queue drained at end", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_display_scan.md
# timer_display_scan

Multiplexed seven-segment display scanner that reads the BCD digit outputs of a chain of `timer10` counters. It drives one common-anode digit at a time, sits downstream of the counter chain, and ships with the timer on the board. It double-buffers the digits so a display frame is never torn, shows a dash for non-BCD codes, and flashes the display after a rollover of the most-significant digit.

## Interface
- `DIGITS`, 4, number of digits scanned (1..8); digit 0 is least significant
- `SCAN_DIV`, 1000, clock cycles each digit stays lit (>= 2)
- `FLASH_FRAMES`, 8, frames of flashing after a rollover pulse (1..255)

- `Clk`  in  1  single clock; everything rises on posedge
- `reset`  in  1  asynchronous, active-high
- `digits_in`  in  4*DIGITS  BCD digits; digit i is in bits [4i+3:4i]
- `load`  in  1  captures `digits_in` into the shadow register
- `rollover`  in  1  one-cycle pulse (MSD carry) that starts a flash sequence
- `enable`  in  1  0 = display dark and scan frozen
- `seg`  out  7  active-low segments {g,f,e,d,c,b,a}
- `an`  out  DIGITS  active-low one-hot digit enable
- `frame_tick`  out  1  one-cycle pulse per completed frame
- `flashing`  out  1  high while the flash sequence is active

## Operation
- **Reset values.** `seg`=7'h7F, `an`=all ones, `frame_tick`=0, `flashing`=0. Shadow register, display register, divider, digit index and flash counter are all 0.
- **Scan.** When `enable`=1:
  - The divider counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 the digit index advances, wrapping DIGITS-1 -> 0.
  - The **frame boundary** is the cycle where divider = SCAN_DIV-1 and index = DIGITS-1.
- **Buffering.**
  - `load`=1 writes the shadow register at that edge.
  - The display register copies the shadow only at the frame boundary edge.
  - If `load` and the frame boundary coincide, the display takes the old shadow and the new value appears one frame later.
- **Decode.**
  - 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001
  - 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000
  - 10..15 show a dash, 7'b0111111.
- **Flash.**
  - A `rollover` pulse loads the flash counter with FLASH_FRAMES. The counter decrements at each frame boundary down to 0.
  - `flashing` = (counter != 0).
  - All anodes are off for the whole frame while the counter is odd.
  - A `rollover` during flashing restarts the count. A `rollover` coinciding with a frame boundary: the reload wins.
- **Disable.** With `enable`=0:
  - `an`=all ones and `seg`=7'h7F from the next edge.
  - Divider, index and flash counter hold; `load` still updates the shadow.
  - With `enable`=1 again, the scan resumes from the held position.

## Timing
- `seg` and `an` are registered and reflect the index and display register with one cycle of latency.
- Each digit is lit for exactly SCAN_DIV cycles. A frame is DIGITS*SCAN_DIV cycles.
- `frame_tick` is registered and goes high the cycle after the frame boundary edge, for one cycle.
- A digit written by `load` is visible 1..(frame+2) cycles later, depending on frame phase.
- Reset asserted mid-frame forces reset values immediately (asynchronous). The first digit-0 slot starts on the first edge after release.
- DIGITS=1: every slot is a frame boundary.

## Configuration
- Macro `TIMER_DISP_LZ_BLANK_EN` controls leading-zero blanking.
- **Defined:** digit i (i != 0) keeps its anode off when display digits i..DIGITS-1 are all 0.
  - Digit 0 is always shown.
  - Non-BCD digits count as nonzero.
- **Undefined:** every digit is shown, including leading zeros.

## Test plan
- **Basic scan** (DIGITS=4, SCAN_DIV=4, `enable`=1): reset, then `load` 16'h1234 -> after the first frame boundary, `an` steps 1110, 1101, 1011, 0111, 4 cycles each, while `seg` shows 4, 3, 2, 1. `frame_tick` pulses every 16 cycles.
- **Load at boundary:** `load` 16'h5678 on the frame-boundary cycle while 16'h1234 is shown -> the next frame still shows 1234, and the frame after shows 5678.
- **Non-BCD and flash** (FLASH_FRAMES=4):
  - `load` 16'h00A9 -> digit 1 `seg`=7'b0111111, digit 0 `seg`=7'b0010000.
  - Then a one-cycle `rollover` -> frames with counter 3 and 1 are fully dark, frames with counter 4 and 2 are lit, and `flashing` drops after 4 boundaries.
- **Leading-zero blanking:**
  - With the macro defined, 16'h0050 -> `an`[3] and `an`[2] never go low; digits 1 and 0 show 5 and 0. 16'h0000 -> only digit 0 is lit.
  - Without the macro, all four digits are lit.
- **Disable:** drop `enable` mid-slot at index 2 for 10 cycles -> `an`=1111 and `seg`=7'h7F. Then re-enable -> index 2 completes its remaining cycles and no `frame_tick` occurs during the pause.
- **Reset mid-frame:** pulse `reset` during a flash at index 3 -> all outputs take reset values with no clock edge, and `flashing`=0 after release.
